// File: rtl/wishbone_p_decoder_if.sv
// rtl/wishbone_p_decoder_if.sv - pipelined Wishbone master-side and slave-side bus bundle for the decoder
interface wishbone_p_decoder_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int GRANULARITY = 8,
    parameter int SLAVE_COUNT = 4
);
    localparam int SEL_W = DATA_WIDTH / GRANULARITY;

    logic [ADDR_WIDTH-1:0]             m_adr_i;
    logic [DATA_WIDTH-1:0]             m_dat_i;
    logic                              m_we_i;
    logic [SEL_W-1:0]                  m_sel_i;
    logic                              m_stb_i;
    logic                              m_cyc_i;
    logic [DATA_WIDTH-1:0]             m_dat_o;
    logic                              m_ack_o;
    logic                              m_stall_o;
    logic [ADDR_WIDTH-1:0]             s_adr_o;
    logic [DATA_WIDTH-1:0]             s_dat_o;
    logic                              s_we_o;
    logic [SEL_W-1:0]                  s_sel_o;
    logic [SLAVE_COUNT-1:0]            s_stb_o;
    logic [SLAVE_COUNT-1:0]            s_cyc_o;
    logic [SLAVE_COUNT*DATA_WIDTH-1:0] s_dat_i;
    logic [SLAVE_COUNT-1:0]            s_ack_i;
    logic [SLAVE_COUNT-1:0]            s_stall_i;

    // The decoder itself is the slave of the upstream master.
    modport slave (
        input  m_adr_i, m_dat_i, m_we_i, m_sel_i, m_stb_i, m_cyc_i,
        input  s_dat_i, s_ack_i, s_stall_i,
        output m_dat_o, m_ack_o, m_stall_o,
        output s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o
    );

    modport master (
        output m_adr_i, m_dat_i, m_we_i, m_sel_i, m_stb_i, m_cyc_i,
        output s_dat_i, s_ack_i, s_stall_i,
        input  m_dat_o, m_ack_o, m_stall_o,
        input  s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o
    );
endinterface

// File: rtl/wishbone_p_decoder.sv
// rtl/wishbone_p_decoder.sv - 1-to-N pipelined Wishbone address decoder with in-order ack return
module wishbone_p_decoder #(
    parameter int                              DATA_WIDTH      = 32,
    parameter int                              ADDR_WIDTH      = 32,
    parameter int                              GRANULARITY     = 8,
    parameter int                              SLAVE_COUNT     = 4,
    parameter logic [SLAVE_COUNT*ADDR_WIDTH-1:0] SLAVE_BASE    = '0,
    parameter logic [SLAVE_COUNT*ADDR_WIDTH-1:0] SLAVE_MASK    = '0,
    parameter int                              MAX_OUTSTANDING = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    wishbone_p_decoder_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int TGT_W = $clog2(SLAVE_COUNT + 1);
    localparam logic [TGT_W-1:0] DFLT_TGT = TGT_W'(SLAVE_COUNT);

    if (!(GRANULARITY == 8 || GRANULARITY == 16 || GRANULARITY == 32)) begin : g_bad_gran
        $fatal(1, "wishbone_p_decoder: GRANULARITY must be 8, 16 or 32");
    end
    if (SLAVE_COUNT < 1) begin : g_bad_count
        $fatal(1, "wishbone_p_decoder: SLAVE_COUNT must be >= 1");
    end
    if (MAX_OUTSTANDING < 1) begin : g_bad_outst
        $fatal(1, "wishbone_p_decoder: MAX_OUTSTANDING must be >= 1");
    end

    logic [CNT_W-1:0]       r_cnt;
    logic [TGT_W-1:0]       r_cur_tgt;
    logic                   r_dflt_ack;
    logic [TGT_W-1:0]       w_tgt;
    logic                   w_req;
    logic                   w_block;
    logic                   w_slv_stall;
    logic                   w_accept;
    logic                   w_ret_ack;
    logic [DATA_WIDTH-1:0]  w_ret_dat;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_tgt = DFLT_TGT;
        for (int k = SLAVE_COUNT - 1; k >= 0; k--) begin
            if ((bus.m_adr_i & SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
                w_tgt = TGT_W'(k);
            end
        end
    end

    always_comb begin
        w_slv_stall = 1'b0;
        for (int k = 0; k < SLAVE_COUNT; k++) begin
            if (w_tgt == TGT_W'(k)) w_slv_stall = bus.s_stall_i[k];
        end
    end

    assign w_req    = bus.m_cyc_i & bus.m_stb_i;
    assign w_block  = (r_cnt == CNT_W'(MAX_OUTSTANDING)) |
                      ((r_cnt != '0) & (w_tgt != r_cur_tgt));
    assign bus.m_stall_o = w_req & (w_block | w_slv_stall);
    assign w_accept = w_req & ~bus.m_stall_o;

    always_comb begin
        bus.s_stb_o = '0;
        bus.s_cyc_o = '0;
        for (int k = 0; k < SLAVE_COUNT; k++) begin
            bus.s_stb_o[k] = w_req & (w_tgt == TGT_W'(k)) & ~w_block;
            bus.s_cyc_o[k] = bus.m_cyc_i &
                             (((w_tgt == TGT_W'(k)) & bus.m_stb_i & ~w_block) |
                              ((r_cnt != '0) & (r_cur_tgt == TGT_W'(k))));
        end
    end

    assign bus.s_adr_o = bus.m_adr_i;
    assign bus.s_dat_o = bus.m_dat_i;
    assign bus.s_we_o  = bus.m_we_i;
    assign bus.s_sel_o = bus.m_sel_i;

    // Only the slave owning the outstanding transfers may answer.
    always_comb begin
        w_ret_ack = 1'b0;
        w_ret_dat = '0;
        for (int k = 0; k < SLAVE_COUNT; k++) begin
            if (r_cur_tgt == TGT_W'(k)) begin
                w_ret_ack = bus.s_ack_i[k];
                w_ret_dat = bus.s_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (r_cur_tgt == DFLT_TGT) w_ret_ack = r_dflt_ack;
    end

    assign bus.m_ack_o = (r_cnt != '0) & w_ret_ack;
    assign bus.m_dat_o = (r_cnt != '0) ? w_ret_dat : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_cur_tgt  <= '0;
            r_dflt_ack <= 1'b0;
        end else begin
            if (w_accept) r_cur_tgt <= w_tgt;
            if (!bus.m_cyc_i) begin
                r_cnt      <= '0;
                r_dflt_ack <= 1'b0;
            end else begin
                r_cnt      <= r_cnt + CNT_W'(w_accept) - CNT_W'(bus.m_ack_o);
                r_dflt_ack <= w_accept & (w_tgt == DFLT_TGT);
            end
        end
    end
endmodule

// File: tb/tb_wishbone_p_decoder.sv
// tb/tb_wishbone_p_decoder.sv - directed self-checking bench for wishbone_p_decoder
module tb_wishbone_p_decoder;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SC = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wishbone_p_decoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GRANULARITY(8), .SLAVE_COUNT(SC)) bus ();

    wishbone_p_decoder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GRANULARITY(8), .SLAVE_COUNT(SC),
        .SLAVE_BASE({32'h1000_0000, 32'h0000_0000}),
        .SLAVE_MASK({32'hF000_0000, 32'hF000_0000}),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.m_cyc_i   = 1'b0;
        bus.m_stb_i   = 1'b0;
        bus.m_we_i    = 1'b0;
        bus.m_adr_i   = '0;
        bus.m_dat_i   = '0;
        bus.m_sel_i   = 4'hF;
        bus.s_ack_i   = '0;
        bus.s_stall_i = '0;
        bus.s_dat_i   = '0;
    endtask

    task automatic req(input logic [31:0] a, input logic we);
        bus.m_cyc_i = 1'b1;
        bus.m_stb_i = 1'b1;
        bus.m_adr_i = a;
        bus.m_we_i  = we;
        bus.m_dat_i = 32'hCAFE_0000 | a[15:0];
    endtask

    task automatic hold();
        bus.m_cyc_i = 1'b1;
        bus.m_stb_i = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        #1;
        check("rst_ack", bus.m_ack_o, 0);
        check("rst_scyc", bus.s_cyc_o, 0);
        check("rst_sstb", bus.s_stb_o, 0);
        check("rst_mdat", bus.m_dat_o, 0);
        check("rst_cnt", dut.r_cnt, 0);
        req(32'h0000_0000, 1'b0);
        bus.s_stall_i = 2'b01;
        #1;
        check("rst_stall_s0", bus.m_stall_o, 1);
        bus.m_adr_i = 32'h1000_0000;
        #1;
        check("rst_stall_s1", bus.m_stall_o, 0);
        idle();
        rst = 1'b0;
        tick();

        // single read to slave0
        req(32'h0000_0010, 1'b0);
        #1;
        check("t1_sstb", bus.s_stb_o, 2'b01);
        check("t1_stall", bus.m_stall_o, 0);
        check("t1_adr", bus.s_adr_o, 32'h0000_0010);
        tick();
        hold();
        bus.s_ack_i = 2'b01;
        bus.s_dat_i = {32'h0, 32'hDEAD_BEEF};
        #1;
        check("t1_sstb_off", bus.s_stb_o, 2'b00);
        check("t1_scyc_hold", bus.s_cyc_o, 2'b01);
        check("t1_ack", bus.m_ack_o, 1);
        check("t1_dat", bus.m_dat_o, 32'hDEAD_BEEF);
        tick();
        bus.s_ack_i = '0;
        #1;
        check("t1_cnt", dut.r_cnt, 0);
        check("t1_ack_off", bus.m_ack_o, 0);
        idle();
        tick();

        // three back-to-back reads to slave1, acks withheld
        req(32'h1000_0000, 1'b0);
        #1;
        check("t2_stall0", bus.m_stall_o, 0);
        check("t2_sstb0", bus.s_stb_o, 2'b10);
        tick();
        req(32'h1000_0004, 1'b0);
        #1;
        check("t2_stall1", bus.m_stall_o, 0);
        tick();
        req(32'h1000_0008, 1'b0);
        #1;
        check("t2_stall2", bus.m_stall_o, 1);
        check("t2_sstb2", bus.s_stb_o, 2'b00);
        check("t2_cnt_full", dut.r_cnt, 2);
        tick();
        #1;
        check("t2_stall3", bus.m_stall_o, 1);
        tick();
        bus.s_ack_i = 2'b10;
        bus.s_dat_i = {32'h1111_2222, 32'h0};
        #1;
        check("t2_ack", bus.m_ack_o, 1);
        check("t2_ackdat", bus.m_dat_o, 32'h1111_2222);
        check("t2_stall_ackcyc", bus.m_stall_o, 1);
        tick();
        bus.s_ack_i = '0;
        #1;
        check("t2_cnt_after_ack", dut.r_cnt, 1);
        check("t2_stall_go", bus.m_stall_o, 0);
        check("t2_sstb_go", bus.s_stb_o, 2'b10);
        tick();
        hold();
        #1;
        check("t2_cnt2", dut.r_cnt, 2);
        bus.s_ack_i = 2'b10;
        tick();
        tick();
        bus.s_ack_i = '0;
        #1;
        check("t2_drain", dut.r_cnt, 0);
        idle();
        tick();

        // target switch while slave0 outstanding
        req(32'h0000_0000, 1'b0);
        tick();
        req(32'h1000_0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.s_ack_i = 2'b01;
            #1;
            check($sformatf("t3_stall%0d", i), bus.m_stall_o, 1);
            check($sformatf("t3_sstb%0d", i), bus.s_stb_o, 2'b00);
            tick();
        end
        bus.s_ack_i = '0;
        #1;
        check("t3_issue_stall", bus.m_stall_o, 0);
        check("t3_issue_sstb", bus.s_stb_o, 2'b10);
        tick();
        hold();
        bus.s_ack_i = 2'b10;
        #1;
        check("t3_ack1", bus.m_ack_o, 1);
        tick();
        idle();
        tick();

        // unmapped write goes to the default slave
        req(32'h2000_0000, 1'b1);
        #1;
        check("t4_sstb", bus.s_stb_o, 2'b00);
        check("t4_scyc", bus.s_cyc_o, 2'b00);
        check("t4_stall", bus.m_stall_o, 0);
        check("t4_ack_early", bus.m_ack_o, 0);
        tick();
        hold();
        #1;
        check("t4_ack", bus.m_ack_o, 1);
        check("t4_dat", bus.m_dat_o, 0);
        tick();
        #1;
        check("t4_ack_once", bus.m_ack_o, 0);
        check("t4_cnt", dut.r_cnt, 0);
        idle();
        tick();

        // spurious acks
        hold();
        bus.s_ack_i = 2'b10;
        bus.s_dat_i = {32'h5555_5555, 32'h0};
        #1;
        check("t5_ack_cnt0", bus.m_ack_o, 0);
        tick();
        bus.s_ack_i = '0;
        #1;
        check("t5_cnt0", dut.r_cnt, 0);
        req(32'h0000_0020, 1'b0);
        tick();
        hold();
        bus.s_ack_i = 2'b10;
        #1;
        check("t5_ack_wrong", bus.m_ack_o, 0);
        tick();
        bus.s_ack_i = '0;
        #1;
        check("t5_cnt1", dut.r_cnt, 1);
        bus.s_ack_i = 2'b01;
        tick();
        bus.s_ack_i = '0;
        #1;
        check("t5_cnt_done", dut.r_cnt, 0);
        idle();
        tick();

        // abort with two outstanding, late acks, then reset mid-burst
        req(32'h0000_0000, 1'b0);
        tick();
        req(32'h0000_0004, 1'b0);
        tick();
        #1;
        check("t6_cnt2", dut.r_cnt, 2);
        idle();
        #1;
        check("t6_scyc_abort", bus.s_cyc_o, 2'b00);
        check("t6_sstb_abort", bus.s_stb_o, 2'b00);
        tick();
        #1;
        check("t6_cnt_abort", dut.r_cnt, 0);
        hold();
        bus.s_ack_i = 2'b01;
        #1;
        check("t6_late_ack", bus.m_ack_o, 0);
        tick();
        bus.s_ack_i = '0;
        req(32'h1000_0000, 1'b0);
        tick();
        hold();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.s_ack_i = 2'b10;
        #1;
        check("t6_rst_cnt", dut.r_cnt, 0);
        check("t6_rst_ack", bus.m_ack_o, 0);
        check("t6_rst_scyc", bus.s_cyc_o, 2'b00);
        check("t6_rst_mdat", bus.m_dat_o, 0);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
